router_reg: RTL and testbench
=============================

# router_reg

Datapath register stage of the 1x3 router, directly downstream of `router_fsm`. It is driven by the FSM's state strobes and the input port. It does the following:
- latches the packet header;
- drives the byte stream toward the three output FIFOs;
- buffers the byte that arrives while the target FIFO is full;
- accumulates and checks packet parity.

Its `parity_done` and `low_pkt_valid` outputs feed back into `router_fsm`.

## Interface
- `WIDTH`, default 8: byte width of `data_in`/`dout`.
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high for header and payload bytes, low on the parity byte.
- `data_in` in WIDTH: input byte. Header format: [WIDTH-1:2] payload length, [1:0] destination address (0–2 valid, 3 invalid).
- `fifo_full` in 1: full flag of the currently addressed FIFO.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` in 1 each: one-hot state strobes from `router_fsm`.
- `dout` out WIDTH: byte presented to the FIFOs.
- `parity_done` out 1: parity byte has been loaded.
- `low_pkt_valid` out 1: `pkt_valid` fell while in the load-data state.
- `err` out 1: parity mismatch flag for the current packet.

## Operation
- Registers: `header_byte`, `hold_byte`, `internal_parity`, `packet_parity`, `dout`, `parity_done`, `low_pkt_valid`, `err`. All are cleared to 0 by `resetn`=0, immediately and independent of `clock`.
- Header capture: load `data_in` into `header_byte` when `detect_add && pkt_valid && data_in[1:0]!=3`. A header with address 3 is ignored and `header_byte` keeps its value.
- `dout`, priority order:
  - `lfd_state`: `header_byte`;
  - `ld_state && !fifo_full`: `data_in`;
  - `ld_state && fifo_full`: `data_in` goes to `hold_byte` and `dout` holds;
  - `laf_state`: `hold_byte`;
  - otherwise hold.
- `internal_parity`:
  - cleared on `detect_add`;
  - XORed with `header_byte` on `lfd_state`;
  - XORed with `data_in` on `ld_state && pkt_valid && !full_state`.
  - Each payload byte is accumulated exactly once, including a byte diverted to `hold_byte`.
- `packet_parity`: loads `data_in` on `ld_state && !pkt_valid`. This covers the parity byte whether or not it is diverted.
- `low_pkt_valid`: set on `ld_state && !pkt_valid`; cleared on `rst_int_reg`. Set takes priority if both occur.
- `parity_done`:
  - set on `ld_state && !fifo_full && !pkt_valid`, or on `laf_state && low_pkt_valid && !parity_done`;
  - cleared on `detect_add`; the set condition wins if both occur.
- `err`: in every cycle with `parity_done`=1, `err <= (internal_parity != packet_parity)`. Cleared on `detect_add`; otherwise holds.

## Timing
- Every output is registered, with one-cycle latency from the qualifying strobe/input edge.
- `dout` shows the header one cycle after `lfd_state`. Payload appears one cycle after each `ld_state` byte.
- `err` is valid one cycle after `parity_done` rises and stays stable until the next `detect_add`.
- Simultaneous `fifo_full` and parity byte in `ld_state`:
  - the byte goes to `hold_byte` and `packet_parity`;
  - `parity_done` is set later, in `laf_state`.
- Reset mid-packet:
  - all state clears at once;
  - the next packet starts clean from `detect_add`;
  - no stale `err`, `parity_done` or `low_pkt_valid` remains.
- The upstream source holds `data_in` stable while `router_fsm` asserts `busy`. This block does not re-sample around it.

## Structure
- Shared package `router_pkg`: `WIDTH` default, `ADDR_INVALID = 2'b11`, and address field slice constants. The same package is used by `router_fsm` and the FIFOs.
- One natural sub-module: `router_parity_unit`. It holds `internal_parity`, `packet_parity`, `parity_done` and `err`, taking the strobes plus `data_in`/`header_byte`.
- The rest (header, hold, `dout`, `low_pkt_valid`) stays in the top level.

## Test plan
- Clean packet: header 8'h0D (length 3, address 1), payload 8'h11/8'h22/8'h33, parity 8'h0D, `fifo_full`=0.
  - `dout` sequence is 0D, 11, 22, 33, 0D.
  - `parity_done` rises after the parity byte; `err`=0.
- Corrupted parity: same packet with parity byte 8'h0C → `err`=1 one cycle after `parity_done`. `err` clears on the next `detect_add`.
- FIFO full mid-payload:
  - `fifo_full`=1 while 8'h22 is presented in `ld_state` → `dout` stays 8'h11.
  - In `laf_state`, `dout`=8'h22.
  - Final `err`=0.
- Full on parity byte: `fifo_full`=1 when 8'h0D parity arrives → `low_pkt_valid`=1 and `parity_done`=0. After `laf_state`, `parity_done`=1 and `err`=0.
- Invalid address: header 8'h07 with `detect_add`, after a prior header 8'h0D → `header_byte` remains 8'h0D.
- Reset mid-payload: drop `resetn` after 8'h11 → all outputs 0 asynchronously. The following clean packet produces `err`=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: byte width default and header address field layout.
package router_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // Header address field occupies the two LSBs; code 3 is reserved as invalid.
    localparam int         ADDR_LSB     = 0;
    localparam int         ADDR_MSB     = 1;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // True when a header's address field selects one of the three output FIFOs.
    function automatic logic addr_is_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_unit.sv
// Parity accumulator and checker for one packet: running XOR of header and
// payload, captured parity byte, completion flag and mismatch flag.
module router_parity_unit
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             pkt_valid,
    input  logic             fifo_full,
    input  logic             low_pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] header_byte,
    output logic             parity_done,
    output logic             err
);

    logic [WIDTH-1:0] internal_parity_q, internal_parity_d;
    logic [WIDTH-1:0] packet_parity_q,   packet_parity_d;
    logic             parity_done_q,     parity_done_d;
    logic             err_q,             err_d;

    // Next-state logic for all parity bookkeeping.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        parity_done_d     = parity_done_q;
        err_d             = err_q;

        // Strobes are one-hot; a byte diverted while full is accumulated here,
        // and the later replay from the hold register is not.
        if (detect_add) begin
            internal_parity_d = '0;
        end else if (lfd_state) begin
            internal_parity_d = internal_parity_q ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            internal_parity_d = internal_parity_q ^ data_in;
        end

        // The parity byte is captured even when it is diverted to the hold register.
        if (ld_state && !pkt_valid) begin
            packet_parity_d = data_in;
        end

        // A diverted parity byte completes only once it is replayed in laf_state.
        if ((ld_state && !fifo_full && !pkt_valid) ||
            (laf_state && low_pkt_valid && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end else if (detect_add) begin
            parity_done_d = 1'b0;
        end

        // A new packet clears the flag; until then it tracks the comparison.
        if (detect_add) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (internal_parity_q != packet_parity_q);
        end
    end

    // Parity state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            parity_done_q     <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            parity_done_q     <= parity_done_d;
            err_q             <= err_d;
        end
    end

    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, hold buffer for bytes that
// arrive while the target FIFO is full, FIFO-facing byte stream, and parity.
module router_reg
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] header_byte_q,   header_byte_d;
    logic [WIDTH-1:0] hold_byte_q,     hold_byte_d;
    logic [WIDTH-1:0] dout_q,          dout_d;
    logic             low_pkt_valid_q, low_pkt_valid_d;

    // Header capture, output byte selection, hold buffering and end-of-packet flag.
    always_comb begin
        header_byte_d   = header_byte_q;
        hold_byte_d     = hold_byte_q;
        dout_d          = dout_q;
        low_pkt_valid_d = low_pkt_valid_q;

        // Headers addressed to the reserved code are dropped.
        if (detect_add && pkt_valid && addr_is_valid(data_in[ADDR_MSB:ADDR_LSB])) begin
            header_byte_d = data_in;
        end

        if (lfd_state) begin
            dout_d = header_byte_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_byte_q;
        end

        // Setting wins over the FSM's clear when both happen together.
        if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte_q   <= '0;
            hold_byte_q     <= '0;
            dout_q          <= '0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_byte_q   <= header_byte_d;
            hold_byte_q     <= hold_byte_d;
            dout_q          <= dout_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_unit #(
        .WIDTH (WIDTH)
    ) u_parity (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .pkt_valid     (pkt_valid),
        .fifo_full     (fifo_full),
        .low_pkt_valid (low_pkt_valid_q),
        .data_in       (data_in),
        .header_byte   (header_byte_q),
        .parity_done   (parity_done),
        .err           (err)
    );

    assign dout          = dout_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: the FSM strobes are driven by hand, packet by packet.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    int checks = 0;
    int errors = 0;

    router_reg #(.WIDTH(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One FSM cycle: apply strobes/inputs, take one rising edge, settle 1 time unit.
    // st order: {detect_add, lfd, ld, laf, full_state, rst_int_reg}
    task automatic step(input logic [5:0] st, input logic pv, input logic [7:0] d,
                        input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = ff;
        @(posedge clock);
        #1;
    endtask

    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RI   = 6'b000001;
    localparam logic [5:0] S_IDLE = 6'b000000;

    task automatic test_reset();
        resetn = 1'b1;
        step(S_IDLE, 1'b0, 8'h00, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got %h exp 00", dout);
        end
        checks++;
        if ({parity_done, low_pkt_valid, err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {parity_done, low_pkt_valid, err});
        end
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
    endtask

    // Header 0D, payload 11/22/33, parity byte as given, no backpressure.
    task automatic test_clean_packet(input logic [7:0] par, input logic exp_err,
                                     input string tag);
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h0D, 1'b0);
        checks++;
        if (dout !== 8'h0D) begin errors++; $display("FAIL %s_hdr got %h exp 0D", tag, dout); end
        step(S_LD, 1'b1, 8'h11, 1'b0);
        checks++;
        if (dout !== 8'h11) begin errors++; $display("FAIL %s_b1 got %h exp 11", tag, dout); end
        step(S_LD, 1'b1, 8'h22, 1'b0);
        checks++;
        if (dout !== 8'h22) begin errors++; $display("FAIL %s_b2 got %h exp 22", tag, dout); end
        step(S_LD, 1'b1, 8'h33, 1'b0);
        checks++;
        if (dout !== 8'h33) begin errors++; $display("FAIL %s_b3 got %h exp 33", tag, dout); end
        checks++;
        if (parity_done !== 1'b0) begin errors++; $display("FAIL %s_pd_early got %b exp 0", tag, parity_done); end
        step(S_LD, 1'b0, par, 1'b0);
        checks++;
        if (dout !== par) begin errors++; $display("FAIL %s_par got %h exp %h", tag, dout, par); end
        checks++;
        if ({parity_done, low_pkt_valid} !== 2'b11) begin
            errors++; $display("FAIL %s_pd_lpv got %b exp 11", tag, {parity_done, low_pkt_valid});
        end
        step(S_IDLE, 1'b0, par, 1'b0);
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL %s_err got %b exp %b", tag, err, exp_err); end
        step(S_RI, 1'b0, par, 1'b0);
        checks++;
        if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL %s_lpv_clr got %b exp 0", tag, low_pkt_valid); end
    endtask

    task automatic test_corrupt_parity();
        test_clean_packet(8'h0C, 1'b1, "corrupt");
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        checks++;
        if ({err, parity_done} !== 2'b00) begin
            errors++; $display("FAIL corrupt_clr got %b exp 00", {err, parity_done});
        end
    endtask

    task automatic test_full_mid_payload();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h0D, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b1);
        checks++;
        if (dout !== 8'h11) begin errors++; $display("FAIL fullmid_hold got %h exp 11", dout); end
        step(S_FULL, 1'b1, 8'h22, 1'b1);
        checks++;
        if (dout !== 8'h11) begin errors++; $display("FAIL fullmid_wait got %h exp 11", dout); end
        step(S_LAF, 1'b1, 8'h22, 1'b0);
        checks++;
        if (dout !== 8'h22) begin errors++; $display("FAIL fullmid_laf got %h exp 22", dout); end
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0D, 1'b0);
        step(S_IDLE, 1'b0, 8'h0D, 1'b0);
        checks++;
        if ({parity_done, err} !== 2'b10) begin
            errors++; $display("FAIL fullmid_err got pd/err %b exp 10", {parity_done, err});
        end
        step(S_RI, 1'b0, 8'h0D, 1'b0);
    endtask

    task automatic test_full_on_parity();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h0D, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0D, 1'b1);
        checks++;
        if ({low_pkt_valid, parity_done} !== 2'b10) begin
            errors++; $display("FAIL fullpar_flags got lpv/pd %b exp 10", {low_pkt_valid, parity_done});
        end
        checks++;
        if (dout !== 8'h33) begin errors++; $display("FAIL fullpar_hold got %h exp 33", dout); end
        step(S_FULL, 1'b0, 8'h0D, 1'b1);
        step(S_LAF, 1'b0, 8'h0D, 1'b0);
        checks++;
        if ({parity_done, dout} !== {1'b1, 8'h0D}) begin
            errors++; $display("FAIL fullpar_laf got pd %b dout %h exp 1 0D", parity_done, dout);
        end
        step(S_IDLE, 1'b0, 8'h0D, 1'b0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL fullpar_err got %b exp 0", err); end
        step(S_RI, 1'b0, 8'h0D, 1'b0);
    endtask

    task automatic test_invalid_addr();
        step(S_DA, 1'b1, 8'h07, 1'b0);
        step(S_LFD, 1'b1, 8'h07, 1'b0);
        checks++;
        if (dout !== 8'h0D) begin errors++; $display("FAIL badaddr_hdr got %h exp 0D", dout); end
        step(S_RI, 1'b1, 8'h07, 1'b0);
    endtask

    task automatic reset_pulse(input string tag);
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'd0) begin
            errors++;
            $display("FAIL %s got dout %h pd %b lpv %b err %b exp all 0",
                     tag, dout, parity_done, low_pkt_valid, err);
        end
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_reset_mid_payload();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h0D, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        reset_pulse("rst_mid");
        test_clean_packet(8'h0D, 1'b0, "after_rst");
    endtask

    // Leave err, parity_done and low_pkt_valid all set, then reset.
    task automatic test_reset_stale_flags();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h0D, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b0, 8'h00, 1'b0);
        step(S_IDLE, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({parity_done, low_pkt_valid, err} !== 3'b111) begin
            errors++; $display("FAIL stale_setup got %b exp 111", {parity_done, low_pkt_valid, err});
        end
        reset_pulse("rst_stale");
    endtask

    initial begin
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        fifo_full = 1'b0;
        resetn    = 1'b1;
        test_reset();
        test_clean_packet(8'h0D, 1'b0, "clean");
        test_corrupt_parity();
        test_full_mid_payload();
        test_full_on_parity();
        test_invalid_addr();
        test_reset_mid_payload();
        test_reset_stale_flags();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
